// File: rtl/uart_rx_frame_ctrl.sv
// Frame sequencer behind uart_rx: assembles SOF/CMD/ADDR/DATA/CHK command frames,
// hands good frames downstream over valid/ready and flags/counts framing errors.
//
// state  | meaning
// S_HUNT | waiting for SOF byte, other bytes ignored
// S_CMD  | next byte is CMD
// S_ADDR | next byte is ADDR
// S_DATA | next byte is DATA
// S_CHK  | next byte is checksum (CMD^ADDR^DATA)
module uart_rx_frame_ctrl #(
   parameter logic [7:0] SOF_BYTE       = 8'hA5,
   parameter int         TIMEOUT_CYCLES = 104160,
   parameter int         CNT_W          = 16
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [7:0]       i_rx_data,
   input  logic             i_rx_valid,
   output logic [7:0]       o_cmd,
   output logic [7:0]       o_addr,
   output logic [7:0]       o_data,
   output logic             o_frame_valid,
   input  logic             i_frame_ready,
   output logic             o_err_chk,
   output logic             o_err_timeout,
   output logic             o_err_ovf,
   output logic [CNT_W-1:0] o_good_cnt,
   output logic [CNT_W-1:0] o_err_cnt
);

   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_HUNT,
      S_CMD,
      S_ADDR,
      S_DATA,
      S_CHK
   } state_t;

   state_t           state;
   logic [7:0]       cmd_sh;
   logic [7:0]       addr_sh;
   logic [7:0]       data_sh;
   logic [TMO_W-1:0] tmo_cnt;

   logic chk_strobe;
   logic chk_ok;
   logic frame_done;
   logic slot_load;
   logic tmo_expire;
   logic err_any;

   assign chk_strobe = (state == S_CHK) && i_rx_valid;
   assign chk_ok     = (i_rx_data == (cmd_sh ^ addr_sh ^ data_sh));
   assign frame_done = chk_strobe && chk_ok;
   // A completing frame may take the slot when it is empty or being drained this cycle.
   assign slot_load  = frame_done && (!o_frame_valid || i_frame_ready);
   assign tmo_expire = (state != S_HUNT) && !i_rx_valid && (tmo_cnt == TMO_LAST);
   assign err_any    = (chk_strobe && !chk_ok) || tmo_expire || (frame_done && !slot_load);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state         <= S_HUNT;
         cmd_sh        <= '0;
         addr_sh       <= '0;
         data_sh       <= '0;
         tmo_cnt       <= '0;
         o_cmd         <= '0;
         o_addr        <= '0;
         o_data        <= '0;
         o_frame_valid <= 1'b0;
         o_err_chk     <= 1'b0;
         o_err_timeout <= 1'b0;
         o_err_ovf     <= 1'b0;
         o_good_cnt    <= '0;
         o_err_cnt     <= '0;
      end else begin
         o_err_chk     <= chk_strobe && !chk_ok;
         o_err_timeout <= tmo_expire;
         o_err_ovf     <= frame_done && !slot_load;

         if (state == S_HUNT || i_rx_valid || tmo_expire)
            tmo_cnt <= '0;
         else
            tmo_cnt <= tmo_cnt + 1'b1;

         if (tmo_expire) begin
            state <= S_HUNT;
         end else if (i_rx_valid) begin
            case (state)
               S_HUNT: if (i_rx_data == SOF_BYTE) state <= S_CMD;
               S_CMD: begin
                  cmd_sh <= i_rx_data;
                  state  <= S_ADDR;
               end
               S_ADDR: begin
                  addr_sh <= i_rx_data;
                  state   <= S_DATA;
               end
               S_DATA: begin
                  data_sh <= i_rx_data;
                  state   <= S_CHK;
               end
               default: state <= S_HUNT;
            endcase
         end

         if (slot_load) begin
            o_cmd         <= cmd_sh;
            o_addr        <= addr_sh;
            o_data        <= data_sh;
            o_frame_valid <= 1'b1;
         end else if (o_frame_valid && i_frame_ready) begin
            o_frame_valid <= 1'b0;
         end

         if (slot_load && (o_good_cnt != {CNT_W{1'b1}}))
            o_good_cnt <= o_good_cnt + 1'b1;
         if (err_any && (o_err_cnt != {CNT_W{1'b1}}))
            o_err_cnt <= o_err_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl with a short timeout and narrow counters.
module tb_uart_rx_frame_ctrl;

   localparam int T     = 40;
   localparam int CNT_W = 3;

   logic             clk = 1'b0;
   logic             reset;
   logic [7:0]       rx_data;
   logic             rx_valid;
   logic [7:0]       cmd, addr, data;
   logic             frame_valid;
   logic             frame_ready;
   logic             err_chk, err_timeout, err_ovf;
   logic [CNT_W-1:0] good_cnt, err_cnt;

   int checks = 0;
   int errors = 0;

   uart_rx_frame_ctrl #(.SOF_BYTE(8'hA5), .TIMEOUT_CYCLES(T), .CNT_W(CNT_W)) dut (
      .i_clk         (clk),
      .i_reset       (reset),
      .i_rx_data     (rx_data),
      .i_rx_valid    (rx_valid),
      .o_cmd         (cmd),
      .o_addr        (addr),
      .o_data        (data),
      .o_frame_valid (frame_valid),
      .i_frame_ready (frame_ready),
      .o_err_chk     (err_chk),
      .o_err_timeout (err_timeout),
      .o_err_ovf     (err_ovf),
      .o_good_cnt    (good_cnt),
      .o_err_cnt     (err_cnt)
   );

   always #5 clk = ~clk;

   // Called at a negedge; the byte is seen by exactly one posedge.
   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] c, input logic [7:0] a,
                             input logic [7:0] d, input logic [7:0] k);
      send_byte(8'hA5);
      send_byte(c);
      send_byte(a);
      send_byte(d);
      send_byte(k);
   endtask

   task automatic test_reset();
      reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; frame_ready = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({cmd, addr, data, frame_valid, err_chk, err_timeout, err_ovf, good_cnt, err_cnt} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got cmd=%h addr=%h data=%h v=%b ec=%b et=%b eo=%b g=%0d e=%0d want all 0",
                  cmd, addr, data, frame_valid, err_chk, err_timeout, err_ovf, good_cnt, err_cnt);
      end
   endtask

   task automatic test_good_frame();
      send_frame(8'h01, 8'h10, 8'h55, 8'h44);
      checks++;
      if ({frame_valid, cmd, addr, data} !== {1'b1, 8'h01, 8'h10, 8'h55}) begin
         errors++;
         $display("FAIL good_frame got v=%b %h %h %h want 1 01 10 55", frame_valid, cmd, addr, data);
      end
      checks++;
      if ({good_cnt, err_cnt, err_chk, err_timeout, err_ovf} !== {3'd1, 3'd0, 3'b000}) begin
         errors++;
         $display("FAIL good_counts got g=%0d e=%0d errs=%b%b%b want 1 0 000",
                  good_cnt, err_cnt, err_chk, err_timeout, err_ovf);
      end
      @(negedge clk);
      checks++;
      if ({frame_valid, cmd} !== {1'b0, 8'h01}) begin
         errors++;
         $display("FAIL good_accept got v=%b cmd=%h want 0 01", frame_valid, cmd);
      end
   endtask

   task automatic test_bad_chk();
      send_frame(8'h01, 8'h10, 8'h55, 8'h45);
      checks++;
      if ({err_chk, frame_valid, err_cnt, good_cnt} !== {1'b1, 1'b0, 3'd1, 3'd1}) begin
         errors++;
         $display("FAIL bad_chk got ec=%b v=%b e=%0d g=%0d want 1 0 1 1", err_chk, frame_valid, err_cnt, good_cnt);
      end
      @(negedge clk);
      checks++;
      if (err_chk !== 1'b0) begin
         errors++;
         $display("FAIL bad_chk_pulse got %b want 0", err_chk);
      end
   endtask

   task automatic test_garbage();
      send_byte(8'h00);
      send_byte(8'hFF);
      send_byte(8'h13);
      checks++;
      if ({err_chk, err_timeout, err_ovf, err_cnt} !== {3'b000, 3'd1}) begin
         errors++;
         $display("FAIL garbage_silent got errs=%b%b%b e=%0d want 000 1", err_chk, err_timeout, err_ovf, err_cnt);
      end
      send_frame(8'h01, 8'h10, 8'h55, 8'h44);
      checks++;
      if ({frame_valid, cmd, addr, data, good_cnt} !== {1'b1, 8'h01, 8'h10, 8'h55, 3'd2}) begin
         errors++;
         $display("FAIL garbage_frame got v=%b %h %h %h g=%0d want 1 01 10 55 2",
                  frame_valid, cmd, addr, data, good_cnt);
      end
      @(negedge clk);
   endtask

   task automatic test_timeout();
      send_byte(8'hA5);
      send_byte(8'h01);
      repeat (T - 1) @(negedge clk);
      checks++;
      if (err_timeout !== 1'b0) begin
         errors++;
         $display("FAIL timeout_early got %b want 0 after %0d idle", err_timeout, T - 1);
      end
      @(negedge clk);
      checks++;
      if ({err_timeout, err_cnt} !== {1'b1, 3'd2}) begin
         errors++;
         $display("FAIL timeout_pulse got et=%b e=%0d want 1 2", err_timeout, err_cnt);
      end
      // T-1 idle clocks then a byte on the expiry clock: byte wins.
      send_byte(8'hA5);
      repeat (T - 1) @(negedge clk);
      send_byte(8'h02);
      checks++;
      if (err_timeout !== 1'b0) begin
         errors++;
         $display("FAIL timeout_byte_wins got %b want 0", err_timeout);
      end
      send_byte(8'h20);
      send_byte(8'h33);
      send_byte(8'h11);
      checks++;
      if ({frame_valid, cmd, addr, data, good_cnt, err_cnt} !== {1'b1, 8'h02, 8'h20, 8'h33, 3'd3, 3'd2}) begin
         errors++;
         $display("FAIL timeout_recover got v=%b %h %h %h g=%0d e=%0d want 1 02 20 33 3 2",
                  frame_valid, cmd, addr, data, good_cnt, err_cnt);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      frame_ready = 1'b0;
      send_frame(8'h01, 8'h10, 8'h55, 8'h44);
      send_frame(8'h02, 8'h20, 8'h33, 8'h11);
      checks++;
      if ({err_ovf, frame_valid, cmd, addr, data, good_cnt, err_cnt} !==
          {1'b1, 1'b1, 8'h01, 8'h10, 8'h55, 3'd4, 3'd3}) begin
         errors++;
         $display("FAIL ovf got eo=%b v=%b %h %h %h g=%0d e=%0d want 1 1 01 10 55 4 3",
                  err_ovf, frame_valid, cmd, addr, data, good_cnt, err_cnt);
      end
      send_byte(8'hA5);
      send_byte(8'h0C);
      send_byte(8'h0A);
      send_byte(8'h03);
      frame_ready = 1'b1;
      send_byte(8'h05);
      frame_ready = 1'b0;
      checks++;
      if ({err_ovf, frame_valid, cmd, addr, data, good_cnt, err_cnt} !==
          {1'b0, 1'b1, 8'h0C, 8'h0A, 8'h03, 3'd5, 3'd3}) begin
         errors++;
         $display("FAIL handoff got eo=%b v=%b %h %h %h g=%0d e=%0d want 0 1 0c 0a 03 5 3",
                  err_ovf, frame_valid, cmd, addr, data, good_cnt, err_cnt);
      end
      frame_ready = 1'b1;
      @(negedge clk);
      checks++;
      if ({frame_valid, cmd} !== {1'b0, 8'h0C}) begin
         errors++;
         $display("FAIL drain got v=%b cmd=%h want 0 0c", frame_valid, cmd);
      end
   endtask

   task automatic test_reset_midframe();
      frame_ready = 1'b0;
      send_frame(8'h01, 8'h10, 8'h55, 8'h44);
      send_byte(8'hA5);
      send_byte(8'h07);
      send_byte(8'h08);
      reset    = 1'b1;
      rx_data  = 8'h09;
      rx_valid = 1'b1;
      @(negedge clk);
      reset    = 1'b0;
      rx_valid = 1'b0;
      checks++;
      if ({cmd, addr, data, frame_valid, err_chk, err_timeout, err_ovf, good_cnt, err_cnt} !== '0) begin
         errors++;
         $display("FAIL midframe_reset got cmd=%h addr=%h data=%h v=%b g=%0d e=%0d want all 0",
                  cmd, addr, data, frame_valid, good_cnt, err_cnt);
      end
      frame_ready = 1'b1;
      send_frame(8'h01, 8'h10, 8'h55, 8'h44);
      checks++;
      if ({frame_valid, cmd, addr, data, good_cnt, err_cnt, err_chk} !==
          {1'b1, 8'h01, 8'h10, 8'h55, 3'd1, 3'd0, 1'b0}) begin
         errors++;
         $display("FAIL post_reset_frame got v=%b %h %h %h g=%0d e=%0d ec=%b want 1 01 10 55 1 0 0",
                  frame_valid, cmd, addr, data, good_cnt, err_cnt, err_chk);
      end
      @(negedge clk);
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 7; i++) begin
         send_frame(8'h01, 8'h10, 8'h55, 8'h44);
         @(negedge clk);
      end
      checks++;
      if (good_cnt !== 3'd7) begin
         errors++;
         $display("FAIL good_sat got %0d want 7", good_cnt);
      end
      for (int i = 0; i < 8; i++) send_frame(8'h01, 8'h10, 8'h55, 8'h00);
      checks++;
      if ({err_cnt, err_chk} !== {3'd7, 1'b1}) begin
         errors++;
         $display("FAIL err_sat got e=%0d ec=%b want 7 1", err_cnt, err_chk);
      end
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_bad_chk();
      test_garbage();
      test_timeout();
      test_back_to_back();
      test_reset_midframe();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
